// File: rtl/led_pwm_dimmer.sv
// led_pwm_dimmer
//   Multi-channel LED brightness PWM generator. Each channel takes a
//   logarithmic brightness level, maps it to a duty-slot count and drives a
//   registered PWM output. Duty changes take effect only at PWM-period
//   boundaries, so a period is never cut short or stretched. With fade_en set,
//   the active duty ramps one slot at a time toward its target.
//
// Ports
//   clk           system clock
//   reset         synchronous, active-high reset
//   enable        global output enable (0 forces pwm_out low; timing and
//                 fade progress keep running)
//   fade_en       1 = ramp duty toward target, 0 = jump at next boundary
//   level         per-channel brightness, channel n at [n*LEVEL_BITS +: LEVEL_BITS]
//   pwm_out       registered PWM drive, one bit per channel
//   period_start  one-cycle pulse on the first clk of each PWM period
//   fading        per channel, 1 while active duty differs from target
module led_pwm_dimmer #(
  parameter int CHANNELS     = 4,
  parameter int RES_BITS     = 4,
  parameter int PRESCALE     = 401,
  parameter int LEVEL_BITS   = 3,
  parameter int FADE_PERIODS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           fade_en,
  input  logic [CHANNELS*LEVEL_BITS-1:0] level,
  output logic [CHANNELS-1:0]            pwm_out,
  output logic                           period_start,
  output logic [CHANNELS-1:0]            fading
);

  localparam int PS_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int FD_W   = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
  // Duty needs one extra bit so that "all slots on" (2^RES_BITS) is encodable.
  localparam int DUTY_W = RES_BITS + 1;

  localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
  localparam logic [FD_W-1:0]   FADE_LAST = FD_W'(FADE_PERIODS - 1);
  localparam logic [DUTY_W-1:0] DUTY_ONE  = DUTY_W'(1);

  // Level L maps to 2^L slots; levels beyond the resolution mean "off".
  function automatic logic [DUTY_W-1:0] level_to_target(
    input logic [LEVEL_BITS-1:0] lvl
  );
    if (int'(lvl) <= RES_BITS) begin
      return DUTY_ONE << lvl;
    end
    return '0;
  endfunction

  // One-slot move toward the target; never passes it, so it cannot leave
  // the 0..2^RES_BITS range as long as the target is inside it.
  function automatic logic [DUTY_W-1:0] step_toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] tgt
  );
    if (cur < tgt) begin
      return cur + DUTY_ONE;
    end
    if (cur > tgt) begin
      return cur - DUTY_ONE;
    end
    return cur;
  endfunction

  logic [PS_W-1:0]     ps_cnt_q, ps_cnt_d;
  logic [RES_BITS-1:0] slot_q, slot_d;
  logic [FD_W-1:0]     fade_cnt_q, fade_cnt_d;
  logic [DUTY_W-1:0]   cur_q [CHANNELS];
  logic [DUTY_W-1:0]   cur_d [CHANNELS];
  logic [DUTY_W-1:0]   tgt   [CHANNELS];
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic [CHANNELS-1:0] fading_q, fading_d;
  logic                period_start_q;

  logic slot_tick;
  logic period_end;
  logic fade_step;

  assign slot_tick  = (ps_cnt_q == PS_LAST);
  assign period_end = slot_tick && (slot_q == {RES_BITS{1'b1}});
  assign fade_step  = period_end && (fade_cnt_q == FADE_LAST);

  // Timing chain: prescaler -> slot counter -> fade period counter.
  always_comb begin
    ps_cnt_d   = slot_tick ? '0 : ps_cnt_q + PS_W'(1);
    slot_d     = slot_tick ? slot_q + RES_BITS'(1) : slot_q;
    fade_cnt_d = fade_cnt_q;
    if (period_end) begin
      fade_cnt_d = (fade_cnt_q == FADE_LAST) ? '0 : fade_cnt_q + FD_W'(1);
    end
  end

  // Per-channel duty update, only at the period boundary. Level inputs are
  // looked at every cycle but only matter at that one instant.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      tgt[n]   = level_to_target(level[n*LEVEL_BITS +: LEVEL_BITS]);
      cur_d[n] = cur_q[n];
      if (period_end) begin
        if (!fade_en) begin
          cur_d[n] = tgt[n];
        end else if (fade_step) begin
          cur_d[n] = step_toward(cur_q[n], tgt[n]);
        end
      end
      pwm_d[n]    = enable && ({1'b0, slot_q} < cur_q[n]);
      fading_d[n] = (cur_q[n] != tgt[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ps_cnt_q       <= '0;
      slot_q         <= '0;
      fade_cnt_q     <= '0;
      pwm_q          <= '0;
      fading_q       <= '0;
      period_start_q <= 1'b0;
      for (int n = 0; n < CHANNELS; n++) begin
        cur_q[n] <= '0;
      end
    end else begin
      ps_cnt_q       <= ps_cnt_d;
      slot_q         <= slot_d;
      fade_cnt_q     <= fade_cnt_d;
      pwm_q          <= pwm_d;
      fading_q       <= fading_d;
      period_start_q <= period_end;
      for (int n = 0; n < CHANNELS; n++) begin
        cur_q[n] <= cur_d[n];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign fading       = fading_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Directed testbench for led_pwm_dimmer with PRESCALE=2, RES_BITS=4 and
// FADE_PERIODS=2: one PWM period is 32 clk, a duty of D slots is 2*D clk high.
module tb_led_pwm_dimmer;

  localparam int CH = 4;
  localparam int RB = 4;
  localparam int PS = 2;
  localparam int LB = 3;
  localparam int FP = 2;
  localparam int PER = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b1;
  logic              fade_en = 1'b0;
  logic [CH*LB-1:0]  level = '0;
  logic [CH-1:0]     pwm_out;
  logic              period_start;
  logic [CH-1:0]     fading;

  int n_chk  = 0;
  int n_pass = 0;

  int         hi  [0:39][0:3];
  logic [3:0] fad [0:39];
  int         d   [0:39];

  always #5 clk = ~clk;

  led_pwm_dimmer #(
    .CHANNELS(CH), .RES_BITS(RB), .PRESCALE(PS), .LEVEL_BITS(LB), .FADE_PERIODS(FP)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .fade_en(fade_en), .level(level),
    .pwm_out(pwm_out), .period_start(period_start), .fading(fading)
  );

  task automatic set_levels(input int l0, input int l1, input int l2, input int l3);
    level = {3'(l3), 3'(l2), 3'(l1), 3'(l0)};
  endtask

  // Leaves the bench at the negedge of a period_start cycle.
  task automatic sync_ps(input string tag);
    int n;
    n = 0;
    while (period_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (period_start !== 1'b1) begin
      n_chk++;
      $display("FAIL %s_sync: period_start=%b after %0d cycles, required 1", tag, period_start, n);
    end
  endtask

  // Called at a period_start negedge; records high-clk counts of np whole
  // consecutive periods (pwm_out lags slot by one clk) and a mid-period
  // fading sample. enable is dropped for windows dis_from..dis_to-1.
  task automatic measure(input int np, input int dis_from, input int dis_to);
    int w;
    for (int k = 0; k < np; k++) begin
      for (int c = 0; c < CH; c++) hi[k][c] = 0;
    end
    for (int i = 1; i <= np*PER; i++) begin
      @(negedge clk);
      w = (i - 1) / PER;
      for (int c = 0; c < CH; c++) if (pwm_out[c] === 1'b1) hi[w][c]++;
      if ((i - 1) % PER == 16) fad[w] = fading;
      if (i == dis_from*PER) enable = 1'b0;
      if (i == dis_to*PER) enable = 1'b1;
    end
    for (int k = 0; k < np; k++) d[k] = hi[k][0] / 2;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1; enable = 1'b1; fade_en = 1'b0; set_levels(0, 0, 0, 0);
    repeat (4) @(negedge clk);
    n_chk++; if (pwm_out !== 4'b0000) $display("FAIL rst_pwm: got %b, required 0000", pwm_out); else n_pass++;
    n_chk++; if (period_start !== 1'b0) $display("FAIL rst_ps: got %b, required 0", period_start); else n_pass++;
    n_chk++; if (fading !== 4'b0000) $display("FAIL rst_fading: got %b, required 0000", fading); else n_pass++;
    reset = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 100);
    n_chk++; if (n !== 32) $display("FAIL rst_first_ps: first period_start after %0d clk, required 32", n); else n_pass++;
    measure(1, -1, -1);
    n_chk++; if (period_start !== 1'b1) $display("FAIL ps_interval: period_start=%b 32 clk later, required 1", period_start); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_chk++; if (hi[0][c] !== 2) $display("FAIL lvl0_ch%0d: high %0d clk, required 2", c, hi[0][c]); else n_pass++;
    end
    n_chk++; if (fading !== 4'b0000) $display("FAIL lvl0_fading: got %b, required 0000", fading); else n_pass++;
  endtask

  task automatic test_levels;
    int exp_hi [0:3];
    exp_hi = '{4, 8, 16, 32};
    sync_ps("levels");
    set_levels(1, 2, 3, 4);
    measure(2, -1, -1);
    n_chk++; if (hi[0][3] !== 2) $display("FAIL lvl_old_period: ch3 high %0d clk, required 2", hi[0][3]); else n_pass++;
    for (int c = 0; c < CH; c++) begin
      n_chk++; if (hi[1][c] !== exp_hi[c]) $display("FAIL lvl_ch%0d: high %0d clk, required %0d", c, hi[1][c], exp_hi[c]); else n_pass++;
    end
    set_levels(5, 6, 7, 5);
    measure(2, -1, -1);
    for (int c = 0; c < CH; c++) begin
      n_chk++; if (hi[1][c] !== 0) $display("FAIL lvl_off_ch%0d: high %0d clk, required 0", c, hi[1][c]); else n_pass++;
    end
  endtask

  task automatic test_mid_change;
    int w0, w1, late;
    sync_ps("mid");
    set_levels(0, 2, 0, 0);
    measure(2, -1, -1);
    n_chk++; if (hi[1][1] !== 8) $display("FAIL mid_setup: ch1 high %0d clk, required 8", hi[1][1]); else n_pass++;
    w0 = 0; w1 = 0; late = 0;
    for (int i = 1; i <= 2*PER; i++) begin
      @(negedge clk);
      if (pwm_out[1] === 1'b1) begin
        if (i <= PER) w0++; else w1++;
        if (i > 8 && i <= PER) late++;
      end
      if (i == 10) set_levels(0, 3, 0, 0);
    end
    n_chk++; if (w0 !== 8) $display("FAIL mid_cur_period: ch1 high %0d clk, required 8", w0); else n_pass++;
    n_chk++; if (late !== 0) $display("FAIL mid_runt: %0d late high clk, required 0", late); else n_pass++;
    n_chk++; if (w1 !== 16) $display("FAIL mid_next_period: ch1 high %0d clk, required 16", w1); else n_pass++;
  endtask

  // dir=+1 ramps up from start_d to end_d, dir=-1 ramps down.
  task automatic check_ramp(input string tag, input int start_d, input int end_d, input int dir);
    int bad_diff, bad_fad, bad_other, run;
    bad_diff = 0; bad_fad = 0; bad_other = 0;
    for (int w = 1; w < 34; w++) begin
      if (d[w] - d[w-1] != 0 && d[w] - d[w-1] != dir) bad_diff++;
    end
    for (int w = 0; w < 34; w++) begin
      if (fad[w][0] !== (d[w] != end_d)) bad_fad++;
      if (hi[w][1] !== 2 || hi[w][2] !== 2 || hi[w][3] !== 2) bad_other++;
    end
    n_chk++; if (d[0] !== start_d) $display("FAIL %s_start: duty %0d, required %0d", tag, d[0], start_d); else n_pass++;
    n_chk++; if (bad_diff !== 0) $display("FAIL %s_step: %0d bad steps, required 0", tag, bad_diff); else n_pass++;
    for (int v = 2; v <= 15; v++) begin
      run = 0;
      for (int w = 0; w < 34; w++) if (d[w] == v) run++;
      n_chk++; if (run !== 2) $display("FAIL %s_hold_%0d: duty %0d held %0d periods, required 2", tag, v, v, run); else n_pass++;
    end
    n_chk++; if (d[33] !== end_d) $display("FAIL %s_end: duty %0d, required %0d", tag, d[33], end_d); else n_pass++;
    n_chk++; if (bad_fad !== 0) $display("FAIL %s_fading: %0d periods wrong, required 0", tag, bad_fad); else n_pass++;
    n_chk++; if (bad_other !== 0) $display("FAIL %s_other_ch: %0d periods wrong, required 0", tag, bad_other); else n_pass++;
  endtask

  task automatic test_fade;
    sync_ps("fade");
    fade_en = 1'b0;
    set_levels(0, 0, 0, 0);
    measure(2, -1, -1);
    n_chk++; if (hi[1][0] !== 2) $display("FAIL fade_setup: ch0 high %0d clk, required 2", hi[1][0]); else n_pass++;
    fade_en = 1'b1;
    set_levels(4, 0, 0, 0);
    measure(34, -1, -1);
    check_ramp("fade_up", 1, 16, 1);
    set_levels(0, 0, 0, 0);
    measure(34, -1, -1);
    check_ramp("fade_dn", 16, 1, -1);
  endtask

  task automatic test_enable;
    int bad;
    sync_ps("enable");
    set_levels(4, 0, 0, 0);
    measure(8, 4, 7);
    bad = 0;
    for (int w = 4; w <= 6; w++) begin
      for (int c = 0; c < CH; c++) if (hi[w][c] != 0) bad++;
    end
    n_chk++; if (d[0] !== 1) $display("FAIL en_start: duty %0d, required 1", d[0]); else n_pass++;
    n_chk++; if (bad !== 0) $display("FAIL en_off_pwm: %0d nonzero counts, required 0", bad); else n_pass++;
    for (int w = 4; w <= 6; w++) begin
      n_chk++; if (fad[w] !== 4'b0001) $display("FAIL en_off_fading_w%0d: got %b, required 0001", w, fad[w]); else n_pass++;
    end
    n_chk++; if (d[7] !== d[3] + 2) $display("FAIL en_resume: duty %0d, required %0d", d[7], d[3] + 2); else n_pass++;
  endtask

  task automatic test_reset_mid_fade;
    int n;
    int exp0 [0:3];
    int exp1 [0:3];
    exp0 = '{0, 2, 2, 4};
    exp1 = '{0, 2, 2, 2};
    sync_ps("rstfade");
    repeat (18) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_chk++; if (pwm_out !== 4'b0000) $display("FAIL rf_pwm: got %b, required 0000", pwm_out); else n_pass++;
    n_chk++; if (fading !== 4'b0000) $display("FAIL rf_fading: got %b, required 0000", fading); else n_pass++;
    n_chk++; if (period_start !== 1'b0) $display("FAIL rf_ps: got %b, required 0", period_start); else n_pass++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 100);
    n_chk++; if (n !== 32) $display("FAIL rf_slot_restart: period_start after %0d clk, required 32", n); else n_pass++;
    measure(4, -1, -1);
    for (int w = 0; w < 4; w++) begin
      n_chk++; if (hi[w][0] !== exp0[w]) $display("FAIL rf_ch0_w%0d: high %0d clk, required %0d", w, hi[w][0], exp0[w]); else n_pass++;
      n_chk++; if (hi[w][1] !== exp1[w]) $display("FAIL rf_ch1_w%0d: high %0d clk, required %0d", w, hi[w][1], exp1[w]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_levels();
    test_mid_change();
    test_fade();
    test_enable();
    test_reset_mid_fade();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1);
  end

endmodule
